// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef struct packed {
    logic       valid;
    logic [3:0] wa3;
    logic       regWrite;
    logic       memToReg;
    logic       pcSrc;
  } hz_entry_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // M outranks W; the PC register is never taken from a bypass path.
  function automatic logic [1:0] fwdSel(input hz_entry_t m, input hz_entry_t w,
                                        input logic [3:0] ra, input logic [3:0] pcIdx);
    if (ra == pcIdx) return FWD_RF;
    if (m.valid && m.regWrite && (m.wa3 == ra)) return FWD_M;
    if (w.valid && w.regWrite && (w.wa3 == ra)) return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_shadow_pipe.sv
// Shadow copy of per-instruction metadata for the E, M and W stages.
module hazard_shadow_pipe
  import hazard_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst,
  input  logic       hold,
  input  logic       bubble,
  input  hz_entry_t  dEntry,
  input  logic [3:0] dRa1,
  input  logic [3:0] dRa2,
  output hz_entry_t  eEntry,
  output hz_entry_t  mEntry,
  output hz_entry_t  wEntry,
  output logic [3:0] eRa1,
  output logic [3:0] eRa2
);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      eEntry <= '0;
      mEntry <= '0;
      wEntry <= '0;
      eRa1   <= '0;
      eRa2   <= '0;
    end else if (!hold) begin
      wEntry <= mEntry;
      mEntry <= eEntry;
      if (bubble) begin
        eEntry <= '0;
        eRa1   <= '0;
        eRa2   <= '0;
      end else begin
        eEntry <= dEntry;
        eRa1   <= dRa1;
        eRa2   <= dRa2;
      end
    end
  end

endmodule

// File: rtl/hazard_control.sv
// Stall, flush and forwarding control for the 5-stage pipeline, plus a
// saturating count of fetch-stall cycles.
module hazard_control
  import hazard_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int PC_REG = 15
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       WA3D,
  input  logic             RegWriteD,
  input  logic             MemToRegD,
  input  logic             PCSrcD,
  input  logic             BranchTakenE,
  input  logic             MemWaitM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] StallCount
);

  localparam logic [3:0] PcIdx = 4'(PC_REG);

  hz_entry_t  dEntry, eEntry, mEntry, wEntry;
  logic [3:0] eRa1, eRa2;
  logic       ldrStall, pcPend, pcW;

  assign dEntry = '{valid: 1'b1, wa3: WA3D, regWrite: RegWriteD,
                    memToReg: MemToRegD, pcSrc: PCSrcD};

  hazard_shadow_pipe uShadow (
    .Clk    (Clk),
    .Rst    (Rst),
    .hold   (MemWaitM),
    .bubble (FlushE),
    .dEntry (dEntry),
    .dRa1   (RA1D),
    .dRa2   (RA2D),
    .eEntry (eEntry),
    .mEntry (mEntry),
    .wEntry (wEntry),
    .eRa1   (eRa1),
    .eRa2   (eRa2)
  );

  always_comb begin
    ldrStall = eEntry.valid & eEntry.memToReg & eEntry.regWrite &
               ((eEntry.wa3 == RA1D) | (eEntry.wa3 == RA2D));
    pcPend   = PCSrcD | (eEntry.valid & eEntry.pcSrc) | (mEntry.valid & mEntry.pcSrc);
    pcW      = wEntry.valid & wEntry.pcSrc;

    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    // A memory freeze defers any branch squash until the wait clears.
    if (MemWaitM) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
    end else if (BranchTakenE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else begin
      StallF = ldrStall | pcPend;
      StallD = ldrStall;
      FlushD = pcPend | pcW;
      FlushE = ldrStall;
    end

    ForwardAE = fwdSel(mEntry, wEntry, eRa1, PcIdx);
    ForwardBE = fwdSel(mEntry, wEntry, eRa2, PcIdx);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      StallCount <= '0;
    end else if (StallF && (StallCount != '1)) begin
      StallCount <= StallCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_control.sv
// Directed bench for hazard_control with a per-cycle reference model.
module tb_hazard_control;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [3:0] RA1D, RA2D, WA3D;
  logic       RegWriteD, MemToRegD, PCSrcD, BranchTakenE, MemWaitM;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE;
  logic [1:0] ForwardAE, ForwardBE;
  logic [15:0] StallCount;
  logic       sStallF, sStallD, sStallE, sStallM, sFlushD, sFlushE;
  logic [1:0] sForwardAE, sForwardBE;
  logic [3:0] sStallCount;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  hazard_control dut (
    .Clk(Clk), .Rst(Rst), .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .RegWriteD(RegWriteD), .MemToRegD(MemToRegD), .PCSrcD(PCSrcD),
    .BranchTakenE(BranchTakenE), .MemWaitM(MemWaitM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallCount(StallCount)
  );

  hazard_control #(.CNT_W(4)) dutSmall (
    .Clk(Clk), .Rst(Rst), .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .RegWriteD(RegWriteD), .MemToRegD(MemToRegD), .PCSrcD(PCSrcD),
    .BranchTakenE(BranchTakenE), .MemWaitM(MemWaitM),
    .StallF(sStallF), .StallD(sStallD), .StallE(sStallE), .StallM(sStallM),
    .FlushD(sFlushD), .FlushE(sFlushE), .ForwardAE(sForwardAE), .ForwardBE(sForwardBE),
    .StallCount(sStallCount)
  );

  // Reference model: instructions in flight, index 0=E, 1=M, 2=W.
  typedef struct {
    bit v; int wa3; bit rw; bit mtr; bit pcs; int ra1; int ra2;
  } ins_t;
  typedef struct {
    int sf; int sd; int se; int sm; int fd; int fe; int fa; int fb;
  } exp_t;

  ins_t pipe[3];
  int   cnt16 = 0;
  int   cnt4 = 0;

  function automatic int bypass(input int ra);
    if (ra == 15) return 0;
    for (int s = 1; s <= 2; s++)
      if (pipe[s].v && pipe[s].rw && pipe[s].wa3 == ra) return (s == 1) ? 2 : 1;
    return 0;
  endfunction

  function automatic exp_t model();
    exp_t r = '{default: 0};
    bit loadUse, pcPending, pcInW;
    loadUse   = pipe[0].v && pipe[0].mtr && pipe[0].rw &&
                (pipe[0].wa3 == int'(RA1D) || pipe[0].wa3 == int'(RA2D));
    pcPending = PCSrcD || (pipe[0].v && pipe[0].pcs) || (pipe[1].v && pipe[1].pcs);
    pcInW     = pipe[2].v && pipe[2].pcs;
    if (MemWaitM) begin
      r.sf = 1; r.sd = 1; r.se = 1; r.sm = 1;
    end else if (BranchTakenE) begin
      r.fd = 1; r.fe = 1;
    end else begin
      r.sf = (loadUse || pcPending) ? 1 : 0;
      r.sd = loadUse ? 1 : 0;
      r.fd = (pcPending || pcInW) ? 1 : 0;
      r.fe = loadUse ? 1 : 0;
    end
    r.fa = bypass(pipe[0].ra1);
    r.fb = bypass(pipe[0].ra2);
    return r;
  endfunction

  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < 3; i++) pipe[i] <= '{default: 0};
      cnt16 <= 0;
      cnt4  <= 0;
    end else begin
      exp_t m;
      m = model();
      if (m.sf == 1) begin
        cnt16 <= (cnt16 == 65535) ? cnt16 : cnt16 + 1;
        cnt4  <= (cnt4 == 15) ? cnt4 : cnt4 + 1;
      end
      if (!MemWaitM) begin
        pipe[2] <= pipe[1];
        pipe[1] <= pipe[0];
        if (m.fe == 1) pipe[0] <= '{default: 0};
        else pipe[0] <= '{1'b1, int'(WA3D), RegWriteD, MemToRegD, PCSrcD, int'(RA1D), int'(RA2D)};
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  exp_t ce;
  always @(negedge Clk) begin
    ce = model();
    chk("m.StallF", int'(StallF), ce.sf);   chk("m.StallD", int'(StallD), ce.sd);
    chk("m.StallE", int'(StallE), ce.se);   chk("m.StallM", int'(StallM), ce.sm);
    chk("m.FlushD", int'(FlushD), ce.fd);   chk("m.FlushE", int'(FlushE), ce.fe);
    chk("m.FwdA", int'(ForwardAE), ce.fa);  chk("m.FwdB", int'(ForwardBE), ce.fb);
    chk("m.Count", int'(StallCount), cnt16);
    chk("m.sStallF", int'(sStallF), ce.sf); chk("m.sStallD", int'(sStallD), ce.sd);
    chk("m.sStallE", int'(sStallE), ce.se); chk("m.sStallM", int'(sStallM), ce.sm);
    chk("m.sFlushD", int'(sFlushD), ce.fd); chk("m.sFlushE", int'(sFlushE), ce.fe);
    chk("m.sFwdA", int'(sForwardAE), ce.fa); chk("m.sFwdB", int'(sForwardBE), ce.fb);
    chk("m.sCount", int'(sStallCount), cnt4);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic setD(input int ra1, input int ra2, input int wa3,
                      input bit rw, input bit mtr, input bit pcs);
    RA1D = 4'(ra1); RA2D = 4'(ra2); WA3D = 4'(wa3);
    RegWriteD = rw; MemToRegD = mtr; PCSrcD = pcs;
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, ".StallF"}, int'(StallF), 0); chk({tag, ".StallD"}, int'(StallD), 0);
    chk({tag, ".StallE"}, int'(StallE), 0); chk({tag, ".StallM"}, int'(StallM), 0);
    chk({tag, ".FlushD"}, int'(FlushD), 0); chk({tag, ".FlushE"}, int'(FlushE), 0);
    chk({tag, ".FwdA"}, int'(ForwardAE), 0); chk({tag, ".FwdB"}, int'(ForwardBE), 0);
    chk({tag, ".Count"}, int'(StallCount), 0); chk({tag, ".sCount"}, int'(sStallCount), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int expSf[5] = '{1, 1, 1, 0, 0};
    int expFd[5] = '{1, 1, 1, 1, 0};
    Rst = 1'b1; BranchTakenE = 1'b0; MemWaitM = 1'b0;
    setD(0, 0, 0, 0, 0, 0);
    tick(); tick();
    Rst = 1'b0;
    #1 chkAllZero("reset");

    // Load-use: LDR R1 then a reader of R1
    tick(); setD(0, 0, 1, 1, 1, 0);
    #1 chk("ld.noStall", int'(StallF), 0);
    tick(); setD(1, 2, 3, 1, 0, 0);
    #1 chk("ld.StallF", int'(StallF), 1); chk("ld.StallD", int'(StallD), 1);
    chk("ld.FlushE", int'(FlushE), 1); chk("ld.FlushD", int'(FlushD), 0);
    chk("ld.FwdA0", int'(ForwardAE), 0);
    tick();
    #1 chk("ld.bubbleStallF", int'(StallF), 0); chk("ld.bubbleFwdA", int'(ForwardAE), 0);
    tick(); setD(0, 0, 0, 0, 0, 0);
    #1 chk("ld.FwdAW", int'(ForwardAE), 1); chk("ld.FwdBW", int'(ForwardBE), 0);
    chk("ld.Count", int'(StallCount), 1);
    tick(); tick(); tick();

    // Forwarding priority: SUB R2 (W), ADD R2 (M), reader of R2 (E)
    setD(0, 0, 2, 1, 0, 0); tick();
    setD(0, 0, 2, 1, 0, 0); tick();
    setD(2, 2, 4, 1, 0, 0); tick();
    setD(0, 0, 0, 0, 0, 0);
    #1 chk("fw.MA", int'(ForwardAE), 2); chk("fw.MB", int'(ForwardBE), 2);
    tick();
    setD(0, 0, 2, 1, 0, 0); tick();
    setD(0, 0, 2, 0, 0, 0); tick();
    setD(2, 2, 4, 1, 0, 0); tick();
    setD(0, 0, 0, 0, 0, 0);
    #1 chk("fw.WA", int'(ForwardAE), 1); chk("fw.WB", int'(ForwardBE), 1);
    tick();
    setD(0, 0, 15, 1, 0, 0); tick();
    setD(0, 0, 15, 1, 0, 0); tick();
    setD(15, 15, 4, 1, 0, 0); tick();
    setD(0, 0, 0, 0, 0, 0);
    #1 chk("fw.PcA", int'(ForwardAE), 0); chk("fw.PcB", int'(ForwardBE), 0);
    tick(); tick(); tick();

    // Taken branch overrides a load-use match
    setD(0, 0, 5, 1, 1, 0); tick();
    setD(5, 0, 6, 1, 0, 0); BranchTakenE = 1'b1;
    #1 chk("br.FlushD", int'(FlushD), 1); chk("br.FlushE", int'(FlushE), 1);
    chk("br.StallF", int'(StallF), 0); chk("br.StallD", int'(StallD), 0);
    tick(); BranchTakenE = 1'b0; setD(0, 0, 0, 0, 0, 0);
    #1 chk("br.Count", int'(StallCount), 1);
    tick(); tick(); tick();

    // PC write walks D, E, M, W
    setD(0, 0, 15, 1, 0, 1);
    for (int k = 0; k < 5; k++) begin
      #1 chk("pc.StallF", int'(StallF), expSf[k]); chk("pc.FlushD", int'(FlushD), expFd[k]);
      chk("pc.StallD", int'(StallD), 0); chk("pc.FlushE", int'(FlushE), 0);
      tick(); setD(0, 0, 0, 0, 0, 0);
    end
    #1 chk("pc.Count", int'(StallCount), 4);

    // Memory freeze holds a taken branch
    BranchTakenE = 1'b1; MemWaitM = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1 chk("mw.StallF", int'(StallF), 1); chk("mw.StallD", int'(StallD), 1);
      chk("mw.StallE", int'(StallE), 1); chk("mw.StallM", int'(StallM), 1);
      chk("mw.FlushD", int'(FlushD), 0); chk("mw.FlushE", int'(FlushE), 0);
      tick();
    end
    MemWaitM = 1'b0;
    #1 chk("mw.relFlushD", int'(FlushD), 1); chk("mw.relFlushE", int'(FlushE), 1);
    chk("mw.relStallF", int'(StallF), 0); chk("mw.Count", int'(StallCount), 9);
    tick(); BranchTakenE = 1'b0;
    #1 chk("mw.Count2", int'(StallCount), 9);

    // Asynchronous reset while a PC write is in flight
    tick(); setD(0, 0, 15, 1, 0, 1);
    tick(); setD(0, 0, 0, 0, 0, 0);
    #1 chk("ar.pending", int'(StallF), 1);
    #1 Rst = 1'b1;
    #1 chkAllZero("asyncRst");
    tick(); Rst = 1'b0;

    // Saturation of the narrow counter
    #1 MemWaitM = 1'b1;
    repeat (20) tick();
    #1 chk("sat.Count16", int'(StallCount), 20); chk("sat.Count4", int'(sStallCount), 15);
    MemWaitM = 1'b0;
    tick();
    #1 chk("sat.hold4", int'(sStallCount), 15);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_control.md
Name: hazard_control

Overview:
- Hazard and sequencing controller for the 5-stage ARM pipeline (F/D/E/M/W).
- Keeps a shadow pipeline of per-instruction metadata for the E, M and W stages.
- From that state and the decode-stage fields, each cycle it produces stall, flush and forwarding controls.
- It also counts lost cycles for performance debug, and sits beside the decode/execute pipe registers, driving their enables and clears.

Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter.
- PC_REG, 15, register index treated as PC; never a forwarding source.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-high reset.
- RA1D  in  4  source register A of the instruction in D, post RegSrc mux.
- RA2D  in  4  source register B of the instruction in D, post RegSrc mux.
- WA3D  in  4  destination register of the instruction in D.
- RegWriteD  in  1  instruction in D writes the register file.
- MemToRegD  in  1  instruction in D is a load.
- PCSrcD  in  1  instruction in D writes PC.
- BranchTakenE  in  1  branch in E resolved taken, condition already applied.
- MemWaitM  in  1  data memory or camera port not ready; freeze request.
- StallF  out  1  hold PC register.
- StallD  out  1  hold F/D pipe register.
- StallE  out  1  hold D/E pipe register.
- StallM  out  1  hold E/M and M/W pipe registers.
- FlushD  out  1  clear F/D pipe register.
- FlushE  out  1  clear D/E pipe register.
- ForwardAE  out  2  SrcA select in E: 00 register file, 01 ResultW, 10 ALUResultM.
- ForwardBE  out  2  SrcB select in E, same encoding.
- StallCount  out  CNT_W  cycles with StallF=1 since reset; saturates at all-ones.

Behaviour:
- Shadow entry per stage E, M, W: {valid, wa3, regwrite, memtoreg, pcsrc}. E entry also holds ra1, ra2.
- Reset clears all valid bits, entry fields to 0, and StallCount to 0.
- Control outputs are combinational from shadow state plus D inputs. Zero-latency, so the pipe registers act in the same cycle.
- With shadow empty and all inputs 0 after reset, every output is 0.
- Terms:
  - ldrstall = E.valid & E.memtoreg & E.regwrite & (E.wa3==RA1D | E.wa3==RA2D).
  - pcpend = PCSrcD | (E.valid&E.pcsrc) | (M.valid&M.pcsrc).
  - pcW = W.valid & W.pcsrc.
- Priority 1, MemWaitM=1:
  - StallF=StallD=StallE=StallM=1; FlushD=FlushE=0.
  - Shadow holds entirely.
  - A pending branch or flush is deferred until MemWaitM drops; the branch stays in E.
- Priority 2, BranchTakenE=1:
  - FlushD=1, FlushE=1, StallF=0, StallD=0.
  - ldrstall is ignored because the D instruction is squashed.
- Otherwise:
  - StallF = ldrstall | pcpend.
  - StallD = ldrstall.
  - FlushD = pcpend | pcW.
  - FlushE = ldrstall.
  - StallE = StallM = 0.
  - If ldrstall and pcpend are both true, StallD=1 and FlushD=1; flush wins.
- Shadow advance when not frozen:
  - W<=M, M<=E.
  - E<=bubble (valid=0) if FlushE.
  - Else E<=D fields with valid=1; an entry with all zero fields is still valid.
- Forwarding, per operand X in {A,B}, with raX=E.raX:
  - 10 if M.valid & M.regwrite & M.wa3==raX & raX!=PC_REG.
  - Else 01 if W.valid & W.regwrite & W.wa3==raX & raX!=PC_REG.
  - Else 00. M has priority over W.
- Forwarding outputs are valid whether or not MemWaitM is asserted.
- StallCount increments on any cycle with StallF=1. It holds at 2^CNT_W-1, with no wrap.
- Rst asserted mid-operation drops all bubbles and pending PC writes immediately, with no clock required.

Decomposition:
- Package hazard_pkg holds:
  - typedef hz_entry_t, the packed stage entry;
  - forward encoding constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
- One sub-module, hazard_shadow_pipe, holds the E/M/W entry registers with async reset, hold (freeze) and bubble-insert controls.
- Stall/flush/forward/counter logic lives in the top level.

Test Plan:
1. LDR R1 into E (memtoreg=1, wa3=1), D has RA1D=1 -> StallF=1, StallD=1, FlushE=1. Next cycle E.valid=0 and ForwardAE stays 00; one cycle later the load is in W and ForwardAE=01.
2. ADD R2 in M, SUB R2 in W, E instruction reads R2 on both operands -> ForwardAE=10, ForwardBE=10. With M.regwrite=0 instead -> both 01. With RA=15 and a matching writer -> 00.
3. BranchTakenE=1 while a load-use match also exists -> FlushD=1, FlushE=1, StallF=0, StallD=0; StallCount is unchanged.
4. PCSrcD=1 for an instruction writing R15 -> StallF=1 for 3 cycles (D, E, M), FlushD=1 for 4 cycles (D, E, M, W), then all 0.
5. MemWaitM=1 for 5 cycles with BranchTakenE=1 -> all four stalls 1 and flushes 0 for 5 cycles; on the cycle MemWaitM drops, FlushD=FlushE=1. StallCount rises by 5.
6. Assert Rst asynchronously between clock edges during scenario 4 -> outputs go to 0 before the next edge; StallCount=0. With CNT_W=4 forced, 20 stall cycles -> StallCount=15.
